// File: rtl/denoise_frame_scheduler.sv
// Frame sequencer for the spectral-subtraction denoiser: counts sample strobes into frames and
// walks each frame through FFT, subtraction, IFFT and overlap-add with start/done handshakes.
`timescale 1ns / 1ps

module denoise_frame_scheduler #(
    parameter int unsigned FRAME_LEN    = 256,
    parameter int unsigned HOP          = 128,
    parameter int unsigned NOISE_FRAMES = 8,
    parameter int unsigned TIMEOUT      = 4095
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic        fft_done,
    input  logic        sub_done,
    input  logic        ifft_done,
    input  logic        ola_done,
    input  logic        clear_err,
    output logic        fft_start,
    output logic        sub_start,
    output logic        ifft_start,
    output logic        ola_start,
    output logic        noise_learn,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun,
    output logic        timeout_err
);

    localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StFftW,
        StSubW,
        StIfftW,
        StOlaW
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    smp_cnt_q, smp_cnt_d;
    logic           filled_q, filled_d;
    logic           pending_q, pending_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic [7:0]     learn_cnt_q, learn_cnt_d;
    logic           nl_q, nl_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           overrun_q, overrun_d;
    logic           timeout_q, timeout_d;

    logic           take;
    logic           frame_set;
    logic           overrun_ev;
    logic           timeout_ev;
    logic           stage_done;
    logic           wd_expired;
    logic [16:0]    smp_next;
    logic [16:0]    smp_target;

    // Sample counter: first frame needs FRAME_LEN strobes, later ones HOP strobes.
    always_comb begin
        smp_cnt_d  = smp_cnt_q;
        filled_d   = filled_q;
        frame_set  = 1'b0;
        smp_next   = {1'b0, smp_cnt_q} + 17'd1;
        smp_target = filled_q ? 17'(HOP) : 17'(FRAME_LEN);
        if (!enable) begin
            smp_cnt_d = '0;
            filled_d  = 1'b0;
        end else if (sample_valid) begin
            if (smp_next == smp_target) begin
                smp_cnt_d = '0;
                filled_d  = 1'b1;
                frame_set = 1'b1;
            end else begin
                smp_cnt_d = smp_next[15:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            smp_cnt_q   <= '0;
            filled_q    <= 1'b0;
            pending_q   <= 1'b0;
            wd_q        <= '0;
            learn_cnt_q <= '0;
            nl_q        <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            smp_cnt_q   <= smp_cnt_d;
            filled_q    <= filled_d;
            pending_q   <= pending_d;
            wd_q        <= wd_d;
            learn_cnt_q <= learn_cnt_d;
            nl_q        <= nl_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // Stage sequencing and watchdog; the watchdog reads 0 only in the first cycle of a state.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        nl_d        = nl_q;
        learn_cnt_d = learn_cnt_q;
        frame_cnt_d = frame_cnt_q;
        take        = 1'b0;
        timeout_ev  = 1'b0;
        wd_expired  = (wd_q == WdW'(TIMEOUT));

        unique case (state_q)
            StFftW:  stage_done = fft_done;
            StSubW:  stage_done = sub_done;
            StIfftW: stage_done = ifft_done;
            StOlaW:  stage_done = ola_done;
            default: stage_done = 1'b0;
        endcase

        if (state_q == StIdle) begin
            wd_d = '0;
            if (pending_q && enable) begin
                take    = 1'b1;
                state_d = StFftW;
                nl_d    = (learn_cnt_q < 8'(NOISE_FRAMES));
            end
        end else if (stage_done) begin
            wd_d = '0;
            unique case (state_q)
                StFftW:  state_d = StSubW;
                StSubW:  state_d = StIfftW;
                StIfftW: state_d = StOlaW;
                default: begin
                    state_d     = StIdle;
                    nl_d        = 1'b0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (nl_q && (learn_cnt_q < 8'(NOISE_FRAMES))) begin
                        learn_cnt_d = learn_cnt_q + 8'd1;
                    end
                end
            endcase
        end else if (wd_expired) begin
            timeout_ev = 1'b1;
            state_d    = StIdle;
            nl_d       = 1'b0;
            wd_d       = '0;
        end else begin
            wd_d = wd_q + WdW'(1);
        end
    end

    // A new frame in the same cycle the FSM consumes the old one is not an overrun.
    always_comb begin
        pending_d  = pending_q;
        overrun_ev = 1'b0;
        if (!enable) begin
            pending_d = 1'b0;
        end else if (frame_set) begin
            overrun_ev = pending_q && !take;
            pending_d  = 1'b1;
        end else if (take) begin
            pending_d = 1'b0;
        end
        overrun_d = overrun_ev | (overrun_q & ~clear_err);
        timeout_d = timeout_ev | (timeout_q & ~clear_err);
    end

    assign fft_start   = (state_q == StFftW)  && (wd_q == '0);
    assign sub_start   = (state_q == StSubW)  && (wd_q == '0);
    assign ifft_start  = (state_q == StIfftW) && (wd_q == '0);
    assign ola_start   = (state_q == StOlaW)  && (wd_q == '0);
    assign busy        = (state_q != StIdle);
    assign noise_learn = nl_q;
    assign frame_cnt   = frame_cnt_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_denoise_frame_scheduler.sv
// Self-checking bench for denoise_frame_scheduler: directed vector table, corner-case sequences
// and randomized traffic compared every cycle against a frame-level reference model.
`timescale 1ns / 1ps

module tb_denoise_frame_scheduler;

    localparam int unsigned FL = 8;
    localparam int unsigned HP = 4;
    localparam int unsigned NF = 2;
    localparam int unsigned TO = 20;

    typedef struct packed {
        logic rst, en, sv, fd, sd, id, od, clr;
    } in_t;

    typedef struct packed {
        logic [3:0]  st;  // {fft, sub, ifft, ola}
        logic        busy, nl, ovr, to;
        logic [15:0] fc;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0, sample_valid = 1'b0, clear_err = 1'b0;
    logic        fft_done = 1'b0, sub_done = 1'b0, ifft_done = 1'b0, ola_done = 1'b0;
    logic        fft_start, sub_start, ifft_start, ola_start;
    logic        noise_learn, busy, overrun, timeout_err;
    logic [15:0] frame_cnt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state, tracked as "which stage, how long in it" plus frame bookkeeping.
    int unsigned m_stage, m_age, m_samples, m_frames, m_learned;
    bit          m_filled, m_pending, m_over, m_to, m_nl;

    always #5 CLK = ~CLK;

    denoise_frame_scheduler #(
        .FRAME_LEN    (FL),
        .HOP          (HP),
        .NOISE_FRAMES (NF),
        .TIMEOUT      (TO)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .enable       (enable),
        .sample_valid (sample_valid),
        .fft_done     (fft_done),
        .sub_done     (sub_done),
        .ifft_done    (ifft_done),
        .ola_done     (ola_done),
        .clear_err    (clear_err),
        .fft_start    (fft_start),
        .sub_start    (sub_start),
        .ifft_start   (ifft_start),
        .ola_start    (ola_start),
        .noise_learn  (noise_learn),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    function automatic out_t dut_out();
        return {fft_start, sub_start, ifft_start, ola_start, busy, noise_learn, overrun,
                timeout_err, frame_cnt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stage = 0; m_age = 0; m_samples = 0; m_frames = 0; m_learned = 0;
        m_filled = 0; m_pending = 0; m_over = 0; m_to = 0; m_nl = 0;
    endtask

    task automatic model_step(input in_t v);
        logic [3:0] dn;
        bit take, set_p, ovr_ev, to_ev;
        dn = {v.od, v.id, v.sd, v.fd};
        take = (m_stage == 0) && m_pending && v.en;
        set_p = 0; ovr_ev = 0; to_ev = 0;
        if (m_stage == 0) begin
            if (take) begin
                m_stage = 1; m_age = 0; m_nl = (m_learned < NF);
            end
        end else if (dn[m_stage-1]) begin
            if (m_stage == 4) begin
                m_frames = (m_frames + 1) % 65536;
                if (m_nl && m_learned < NF) m_learned++;
                m_stage = 0; m_nl = 0;
            end else begin
                m_stage++; m_age = 0;
            end
        end else if (m_age == TO) begin
            to_ev = 1; m_stage = 0; m_nl = 0;
        end else begin
            m_age++;
        end
        if (!v.en) begin
            m_samples = 0; m_filled = 0; m_pending = 0;
        end else begin
            if (v.sv) begin
                m_samples++;
                if (m_samples == (m_filled ? HP : FL)) begin
                    m_samples = 0; m_filled = 1; set_p = 1;
                end
            end
            if (set_p) begin
                if (m_pending && !take) ovr_ev = 1;
                m_pending = 1;
            end else if (take) begin
                m_pending = 0;
            end
        end
        m_over = ovr_ev ? 1'b1 : (v.clr ? 1'b0 : m_over);
        m_to   = to_ev  ? 1'b1 : (v.clr ? 1'b0 : m_to);
    endtask

    function automatic out_t model_out();
        out_t o;
        logic [3:0] first;
        first = 4'b1000;
        o = '0;
        if (m_stage != 0) begin
            o.busy = 1'b1;
            if (m_age == 0) o.st = first >> (m_stage - 1);
        end
        o.nl = m_nl; o.ovr = m_over; o.to = m_to; o.fc = m_frames[15:0];
        return o;
    endfunction

    // One clock: drive inputs just after an edge, advance the model at the edge, compare 1ns later.
    task automatic step(input in_t v);
        RST = v.rst; enable = v.en; sample_valid = v.sv; clear_err = v.clr;
        fft_done = v.fd; sub_done = v.sd; ifft_done = v.id; ola_done = v.od;
        @(posedge CLK);
        if (v.rst) model_reset(); else model_step(v);
        #1;
        chk("model", 32'(dut_out()), 32'(model_out()));
    endtask

    // Enabled cycle whose done (for stages selected in ans) comes once the stage is lat cycles old.
    task automatic cyc(input logic en, input logic sv, input int lat, input logic [3:0] ans,
                       input logic clr);
        in_t v;
        v = '0; v.en = en; v.sv = sv; v.clr = clr;
        if (m_stage != 0 && lat >= 0 && int'(m_age) >= lat && ans[m_stage-1]) begin
            case (m_stage)
                1: v.fd = 1'b1;
                2: v.sd = 1'b1;
                3: v.id = 1'b1;
                default: v.od = 1'b1;
            endcase
        end
        step(v);
    endtask

    function automatic vec_t row(input logic [7:0] b, input logic [3:0] st, input logic bz,
                                 input logic nl, input logic [15:0] fc);
        vec_t r;
        r.in  = in_t'(b);
        r.exp = {st, bz, nl, 2'b00, fc};
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        int   cnt;
        int   nb;
        logic rnd_en;
        model_reset();

        // Inputs {rst,en,sv,fd,sd,id,od,clr}; outputs after the edge.
        tbl.push_back(row(8'b1000_0000, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 8; i++) tbl.push_back(row(8'b0110_0000, 4'b0000, 0, 0, 0));
        tbl.push_back(row(8'b0100_0000, 4'b1000, 1, 1, 0));
        tbl.push_back(row(8'b0101_0000, 4'b0100, 1, 1, 0));
        tbl.push_back(row(8'b0100_1000, 4'b0010, 1, 1, 0));
        tbl.push_back(row(8'b0100_0100, 4'b0001, 1, 1, 0));
        tbl.push_back(row(8'b0100_0010, 4'b0000, 0, 0, 1));
        tbl.push_back(row(8'b0100_1000, 4'b0000, 0, 0, 1));
        for (int i = 0; i < 4; i++) tbl.push_back(row(8'b0110_0000, 4'b0000, 0, 0, 1));
        tbl.push_back(row(8'b0100_0010, 4'b1000, 1, 1, 1));
        tbl.push_back(row(8'b0100_1000, 4'b0000, 1, 1, 1));
        tbl.push_back(row(8'b0101_0000, 4'b0100, 1, 1, 1));
        tbl.push_back(row(8'b0100_0000, 4'b0000, 1, 1, 1));
        tbl.push_back(row(8'b0100_1000, 4'b0010, 1, 1, 1));
        tbl.push_back(row(8'b0100_0100, 4'b0001, 1, 1, 1));
        tbl.push_back(row(8'b0100_0011, 4'b0000, 0, 0, 2));
        foreach (tbl[i]) begin
            step(tbl[i].in);
            chk($sformatf("vec%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
        end

        // Third frame, dones 3 cycles after each start: no longer a learning frame.
        for (int i = 0; i < 4; i++) cyc(1, 1, 3, 4'hF, 0);
        chk("f3_not_yet", 32'(fft_start), 0);
        cyc(1, 0, 3, 4'hF, 0);
        chk("f3_fft_start", 32'(fft_start), 1);
        chk("f3_nl", 32'(noise_learn), 0);
        for (int i = 0; i < 40 && frame_cnt != 16'd3; i++) cyc(1, 0, 3, 4'hF, 0);
        chk("f3_frame_cnt", 32'(frame_cnt), 3);

        // Overrun: FFT stalls while two hops arrive.
        for (int i = 0; i < 4; i++) cyc(1, 1, -1, 4'h0, 0);
        cyc(1, 0, -1, 4'h0, 0);
        chk("ovr_fft_start", 32'(fft_start), 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, -1, 4'h0, 0);
            if (i == 3) chk("ovr_after_hop1", 32'(overrun), 0);
        end
        chk("ovr_after_hop2", 32'(overrun), 1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(1, 0, 1, 4'hF, 0);
            cnt += int'(fft_start);
        end
        chk("ovr_extra_frames", 32'(cnt), 1);
        chk("ovr_frame_cnt", 32'(frame_cnt), 5);
        cyc(1, 0, -1, 4'h0, 1);
        chk("ovr_cleared", 32'(overrun), 0);

        // Timeout: ifft_done never arrives.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 4'b1011, 0);
        for (int i = 0; i < 20 && !ifft_start; i++) cyc(1, 0, 0, 4'b1011, 0);
        chk("to_ifft_start", 32'(ifft_start), 1);
        for (int i = 1; i <= 21; i++) begin
            cyc(1, 0, 0, 4'b1011, 0);
            if (i == 20) begin
                chk("to_not_yet", 32'(timeout_err), 0);
                chk("to_busy_before", 32'(busy), 1);
            end
        end
        chk("to_flag", 32'(timeout_err), 1);
        chk("to_idle", 32'(busy), 0);
        chk("to_frame_cnt", 32'(frame_cnt), 5);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 4'hF, 0);
        for (int i = 0; i < 40 && frame_cnt != 16'd6; i++) cyc(1, 0, 0, 4'hF, 0);
        chk("to_next_frame", 32'(frame_cnt), 6);
        chk("to_sticky", 32'(timeout_err), 1);
        cyc(1, 0, 0, 4'hF, 1);
        chk("to_cleared", 32'(timeout_err), 0);

        // Hop completes in the same cycle IDLE consumes the pending frame.
        for (int i = 0; i < 4; i++) step(in_t'(8'b0110_0000));
        step(in_t'(8'b0100_0000));
        for (int i = 0; i < 4; i++) step(in_t'(8'b0110_0000));
        step(in_t'(8'b0101_0000));
        step(in_t'(8'b0110_1000));
        step(in_t'(8'b0110_0100));
        step(in_t'(8'b0110_0010));
        chk("sim_fc_a", 32'(frame_cnt), 7);
        chk("sim_idle", 32'(busy), 0);
        step(in_t'(8'b0110_0000));
        chk("sim_fft_b", 32'(fft_start), 1);
        chk("sim_no_ovr", 32'(overrun), 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1, 0, 0, 4'hF, 0);
            cnt += int'(fft_start);
        end
        chk("sim_start_c", 32'(cnt), 1);
        chk("sim_fc_c", 32'(frame_cnt), 9);
        chk("sim_no_ovr_end", 32'(overrun), 0);

        // Asynchronous reset in SUB_W, then a full refill.
        for (int i = 0; i < 4; i++) cyc(1, 1, -1, 4'h0, 0);
        cyc(1, 0, -1, 4'h0, 0);
        cyc(1, 0, 0, 4'b0001, 0);
        chk("rst_in_sub", 32'(sub_start), 1);
        RST = 1'b1;
        #1;
        chk("rst_async", 32'(dut_out()), 0);
        step(in_t'(8'b1000_0000));
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 4'hF, 0);
            nb += int'(busy);
        end
        chk("rst_refill_idle", 32'(nb), 0);
        cyc(1, 0, 0, 4'hF, 0);
        chk("rst_refill_start", 32'(fft_start), 1);
        chk("rst_learn_again", 32'(noise_learn), 1);

        // Enable drops mid-frame: frame finishes, a fresh fill is needed afterwards.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0, 4'hF, 0);
            cnt += int'(fft_start);
        end
        chk("en_frame_done", 32'(frame_cnt), 1);
        chk("en_idle", 32'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0, 4'hF, 0);
            cnt += int'(fft_start);
        end
        chk("en_no_early_start", 32'(cnt), 0);
        cyc(1, 0, 0, 4'hF, 0);
        chk("en_restart", 32'(fft_start), 1);

        // Random traffic with varying done density against the model.
        rnd_en = 1'b1;
        for (int blk = 0; blk < 6; blk++) begin
            int unsigned pd;
            pd = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 6 : 30);
            for (int i = 0; i < 500; i++) begin
                in_t v;
                if ($urandom_range(0, 39) == 0) rnd_en = ~rnd_en;
                v     = '0;
                v.rst = ($urandom_range(0, 699) == 0);
                v.en  = rnd_en;
                v.sv  = ($urandom_range(0, 1) == 0);
                v.fd  = ($urandom_range(0, pd - 1) == 0);
                v.sd  = ($urandom_range(0, pd - 1) == 0);
                v.id  = ($urandom_range(0, pd - 1) == 0);
                v.od  = ($urandom_range(0, pd - 1) == 0);
                v.clr = ($urandom_range(0, 59) == 0);
                step(v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
